// File: rtl/spi_master_pkg.sv
// ============================================================================
//  Module   : spi_master_pkg
//  Brief    : Shared constants and types for the spi_master scheduler slice.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_master_pkg;

   localparam int WORD_W = 32;

   // spi_master Avalon register map
   localparam logic [1:0] SLAVE_SELECT_ADDR = 2'd0;
   localparam logic [1:0] SPI_DATA_IN_ADDR  = 2'd1;
   localparam logic [1:0] SPI_DATA_OUT_ADDR = 2'd2;

   typedef enum logic [3:0] {
      S_IDLE    = 4'd0,
      S_CHECK   = 4'd1,
      S_WR_DOUT = 4'd2,
      S_WR_CLR  = 4'd3,
      S_WR_SS   = 4'd4,
      S_WAIT    = 4'd5,
      S_RD      = 4'd6,
      S_CAP     = 4'd7,
      S_DONE    = 4'd8
   } sched_state_t;

endpackage

`default_nettype wire

// File: rtl/spi_master_scheduler_if.sv
// ============================================================================
//  Module   : spi_master_scheduler_if
//  Brief    : Requester bundle plus spi_master Avalon bus; slave = scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface spi_master_scheduler_if #(
   parameter int NUM_REQ = 2,
   parameter int SLV_W   = 8
);
   import spi_master_pkg::*;

   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ*SLV_W-1:0]  req_slave;
   logic [NUM_REQ*WORD_W-1:0] req_wdata;
   logic [NUM_REQ-1:0]        resp_valid;
   logic [WORD_W-1:0]         resp_rdata;
   logic                      resp_error;
   logic                      busy;

   logic [1:0]                avm_address;
   logic                      avm_read;
   logic                      avm_write;
   logic [WORD_W-1:0]         avm_writedata;
   logic [WORD_W-1:0]         avm_readdata;

   // The scheduler serves the requesters, so it takes the slave view.
   modport slave (
      input  req, req_slave, req_wdata, avm_readdata,
      output resp_valid, resp_rdata, resp_error, busy,
             avm_address, avm_read, avm_write, avm_writedata
   );

   modport master (
      output req, req_slave, req_wdata, avm_readdata,
      input  resp_valid, resp_rdata, resp_error, busy,
             avm_address, avm_read, avm_write, avm_writedata
   );

endinterface

`default_nettype wire

// File: rtl/spi_rr_arbiter.sv
// ============================================================================
//  Module   : spi_rr_arbiter
//  Brief    : Combinational round-robin pick starting at i_ptr, wrapping upward.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int PTR_W   = 1
) (
   input  wire logic [NUM_REQ-1:0] i_req,
   input  wire logic [PTR_W-1:0]   i_ptr,
   output logic      [NUM_REQ-1:0] o_gnt_oh,
   output logic      [PTR_W-1:0]   o_gnt_idx,
   output logic                    o_valid
);

   function automatic logic [PTR_W-1:0] f_wrap(input logic [PTR_W-1:0] ptr, input int k);
      int j;
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      return PTR_W'(j);
   endfunction

   // Walk from lowest priority to highest so the last hit is the winner.
   always_comb begin
      o_gnt_oh  = '0;
      o_gnt_idx = '0;
      o_valid   = 1'b0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (i_req[f_wrap(i_ptr, k)]) begin
            o_gnt_oh                   = '0;
            o_gnt_oh[f_wrap(i_ptr, k)] = 1'b1;
            o_gnt_idx                  = f_wrap(i_ptr, k);
            o_valid                    = 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/spi_master_scheduler.sv
// ============================================================================
//  Module   : spi_master_scheduler
//  Brief    : Round-robin sharing of one spi_master among NUM_REQ requesters.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_master_scheduler
   import spi_master_pkg::*;
#(
   parameter int NUM_REQ          = 2,
   parameter int NUMBER_SLAVES    = 1,
   parameter int XFER_WAIT_CYCLES = 160,
   parameter int SLV_W            = 8
) (
   input  wire logic             clk,
   input  wire logic             reset_n,
   spi_master_scheduler_if.slave sif
);

   localparam int c_ptr_w = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int c_cnt_w = $clog2(XFER_WAIT_CYCLES + 1);

   sched_state_t         r_state;
   logic [c_ptr_w-1:0]   r_ptr;
   logic [NUM_REQ-1:0]   r_gnt_oh;
   logic [c_ptr_w-1:0]   r_gnt_idx;
   logic [SLV_W-1:0]     r_slave;
   logic [WORD_W-1:0]    r_wdata;
   logic [c_cnt_w-1:0]   r_cnt;
   logic [WORD_W-1:0]    r_rx;
   logic                 r_err;
   logic                 r_busy;
   logic [NUM_REQ-1:0]   r_resp_valid;
   logic [1:0]           r_avm_address;
   logic                 r_avm_read;
   logic                 r_avm_write;
   logic [WORD_W-1:0]    r_avm_writedata;

   logic [NUM_REQ-1:0]   w_gnt_oh;
   logic [c_ptr_w-1:0]   w_gnt_idx;
   logic                 w_gnt_valid;
   logic [SLV_W-1:0]     w_sel_slave;
   logic [WORD_W-1:0]    w_sel_wdata;
   logic [WORD_W-1:0]    w_slave_ext;
   logic [c_ptr_w-1:0]   w_ptr_next;

   spi_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (c_ptr_w)
   ) u_arb (
      .i_req     (sif.req),
      .i_ptr     (r_ptr),
      .o_gnt_oh  (w_gnt_oh),
      .o_gnt_idx (w_gnt_idx),
      .o_valid   (w_gnt_valid)
   );

   always_comb begin
      w_sel_slave = '0;
      w_sel_wdata = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_gnt_oh[i]) begin
            w_sel_slave = sif.req_slave[i*SLV_W +: SLV_W];
            w_sel_wdata = sif.req_wdata[i*WORD_W +: WORD_W];
         end
      end
   end

   assign w_slave_ext = WORD_W'(r_slave);
   assign w_ptr_next  = (int'(r_gnt_idx) == NUM_REQ - 1) ? '0 : r_gnt_idx + 1'b1;

   // Outputs are registered: each branch sets what the next state presents.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state         <= S_IDLE;
         r_ptr           <= '0;
         r_gnt_oh        <= '0;
         r_gnt_idx       <= '0;
         r_slave         <= '0;
         r_wdata         <= '0;
         r_cnt           <= '0;
         r_rx            <= '0;
         r_err           <= 1'b0;
         r_busy          <= 1'b0;
         r_resp_valid    <= '0;
         r_avm_address   <= '0;
         r_avm_read      <= 1'b0;
         r_avm_write     <= 1'b0;
         r_avm_writedata <= '0;
      end else begin
         r_resp_valid    <= '0;
         r_avm_address   <= '0;
         r_avm_read      <= 1'b0;
         r_avm_write     <= 1'b0;
         r_avm_writedata <= '0;
         case (r_state)
            S_IDLE: begin
               if (w_gnt_valid) begin
                  r_gnt_oh  <= w_gnt_oh;
                  r_gnt_idx <= w_gnt_idx;
                  r_slave   <= w_sel_slave;
                  r_wdata   <= w_sel_wdata;
                  r_err     <= 1'b0;
                  r_rx      <= '0;
                  r_busy    <= 1'b1;
                  r_state   <= S_CHECK;
               end
            end
            S_CHECK: begin
               if (w_slave_ext >= WORD_W'(NUMBER_SLAVES)) begin
                  r_err        <= 1'b1;
                  r_resp_valid <= r_gnt_oh;
                  r_state      <= S_DONE;
               end else begin
                  r_avm_write     <= 1'b1;
                  r_avm_address   <= SPI_DATA_OUT_ADDR;
                  r_avm_writedata <= r_wdata;
                  r_state         <= S_WR_DOUT;
               end
            end
            S_WR_DOUT: begin
               r_avm_write     <= 1'b1;
               r_avm_address   <= SPI_DATA_IN_ADDR;
               r_avm_writedata <= '0;
               r_state         <= S_WR_CLR;
            end
            S_WR_CLR: begin
               r_avm_write     <= 1'b1;
               r_avm_address   <= SLAVE_SELECT_ADDR;
               r_avm_writedata <= w_slave_ext;
               r_state         <= S_WR_SS;
            end
            S_WR_SS: begin
               r_cnt   <= c_cnt_w'(XFER_WAIT_CYCLES - 1);
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               if (r_cnt == '0) begin
                  r_avm_read    <= 1'b1;
                  r_avm_address <= SPI_DATA_IN_ADDR;
                  r_state       <= S_RD;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            S_RD: begin
               r_state <= S_CAP;
            end
            S_CAP: begin
               r_rx         <= sif.avm_readdata;
               r_resp_valid <= r_gnt_oh;
               r_state      <= S_DONE;
            end
            S_DONE: begin
               r_ptr   <= w_ptr_next;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign sif.resp_valid    = r_resp_valid;
   assign sif.resp_rdata    = r_rx;
   assign sif.resp_error    = r_err;
   assign sif.busy          = r_busy;
   assign sif.avm_address   = r_avm_address;
   assign sif.avm_read      = r_avm_read;
   assign sif.avm_write     = r_avm_write;
   assign sif.avm_writedata = r_avm_writedata;

endmodule

`default_nettype wire

// File: tb/tb_spi_master_scheduler.sv
// ============================================================================
//  Module   : tb_spi_master_scheduler
//  Brief    : Directed bench with a register-level spi_master stand-in.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_master_scheduler;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   int   cyc     = 0;
   int   errors  = 0;
   int   checks  = 0;

   spi_master_scheduler_if #(.NUM_REQ(2), .SLV_W(8)) sif ();

   spi_master_scheduler #(
      .NUM_REQ          (2),
      .NUMBER_SLAVES    (1),
      .XFER_WAIT_CYCLES (160),
      .SLV_W            (8)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .sif     (sif)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // spi_master stand-in: TX/RX registers, instant frame on slave-select write
   logic [31:0] m_tx   = '0;
   logic [31:0] m_rx   = '0;
   logic [31:0] m_mosi = '0;
   logic [31:0] m_resp = '0;
   int          wr_n     = 0;
   int          rd_n     = 0;
   int          bus_viol = 0;
   logic [1:0]  wr_addr [0:255];
   logic [31:0] wr_data [0:255];
   int          pulse_cnt [0:1];

   initial begin
      pulse_cnt[0] = 0;
      pulse_cnt[1] = 0;
   end

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_tx             <= '0;
         m_rx             <= '0;
         sif.avm_readdata <= '0;
      end else begin
         if (sif.avm_write) begin
            if (wr_n < 256) begin
               wr_addr[wr_n] <= sif.avm_address;
               wr_data[wr_n] <= sif.avm_writedata;
            end
            wr_n <= wr_n + 1;
            case (sif.avm_address)
               2'd2: m_tx <= sif.avm_writedata;
               2'd1: m_rx <= sif.avm_writedata;
               2'd0: begin
                  m_mosi <= m_tx;
                  m_rx   <= m_resp;
               end
               default: ;
            endcase
         end
         if (sif.avm_read) begin
            rd_n             <= rd_n + 1;
            sif.avm_readdata <= (sif.avm_address == 2'd1) ? m_rx : 32'h0;
         end
         if (sif.avm_read && sif.avm_write) bus_viol <= bus_viol + 1;
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++)
         if (sif.resp_valid[i] === 1'b1) pulse_cnt[i] = pulse_cnt[i] + 1;
   end

   // Waits for any response pulse; who = -1 when the budget runs out.
   task automatic wait_any(input bit drop, input int budget, output int who,
                           output int at, output logic [31:0] rd, output logic er);
      who = -1; at = -1; rd = '0; er = 1'b0;
      for (int i = 0; i < budget && who < 0; i++) begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            if (who < 0 && sif.resp_valid[k] === 1'b1) begin
               who = k;
               at  = cyc;
               rd  = sif.resp_rdata;
               er  = sif.resp_error;
               if (drop) sif.req[k] = 1'b0;
            end
         end
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      sif.req = '0; sif.req_slave = '0; sif.req_wdata = '0;
      repeat (3) @(negedge clk);
      checks++;
      if ({sif.resp_valid, sif.resp_error, sif.resp_rdata} !== 35'h0) begin
         errors++;
         $display("FAIL reset_resp: valid=%b err=%b rdata=%h required all 0",
                  sif.resp_valid, sif.resp_error, sif.resp_rdata);
      end
      checks++;
      if ({sif.avm_read, sif.avm_write, sif.avm_address, sif.avm_writedata} !== 36'h0) begin
         errors++;
         $display("FAIL reset_avm: rd=%b wr=%b addr=%0d wd=%h required all 0",
                  sif.avm_read, sif.avm_write, sif.avm_address, sif.avm_writedata);
      end
      checks++;
      if (sif.busy !== 1'b0) begin
         errors++; $display("FAIL reset_busy: got %b required 0", sif.busy);
      end
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_simultaneous(input int first, input int second, input string tag);
      int who1, who2, at; int p0, p1; logic [31:0] rd; logic er;
      @(negedge clk);
      p0 = pulse_cnt[0]; p1 = pulse_cnt[1];
      m_resp = 32'h0000_1111;
      sif.req_slave = 16'h0000;
      sif.req_wdata = {32'h2222_2222, 32'h1111_1111};
      sif.req = 2'b11;
      wait_any(1'b1, 400, who1, at, rd, er);
      wait_any(1'b1, 400, who2, at, rd, er);
      repeat (3) @(negedge clk);
      checks++;
      if (who1 !== first) begin
         errors++; $display("FAIL %s_first: got %0d required %0d", tag, who1, first);
      end
      checks++;
      if (who2 !== second) begin
         errors++; $display("FAIL %s_second: got %0d required %0d", tag, who2, second);
      end
      checks++;
      if (pulse_cnt[0] - p0 !== 1) begin
         errors++; $display("FAIL %s_pulses0: got %0d required 1", tag, pulse_cnt[0] - p0);
      end
      checks++;
      if (pulse_cnt[1] - p1 !== 1) begin
         errors++; $display("FAIL %s_pulses1: got %0d required 1", tag, pulse_cnt[1] - p1);
      end
   endtask

   task automatic test_reject();
      int who, at, c0, w0, r0; logic [31:0] rd; logic er;
      @(negedge clk);
      w0 = wr_n; r0 = rd_n;
      sif.req_slave[15:8] = 8'd5;
      c0 = cyc;
      sif.req[1] = 1'b1;
      wait_any(1'b1, 50, who, at, rd, er);
      checks++;
      if (who !== 1 || at !== c0 + 2) begin
         errors++; $display("FAIL reject_latency: who=%0d at=+%0d required who=1 at=+2", who, at - c0);
      end
      checks++;
      if (er !== 1'b1) begin
         errors++; $display("FAIL reject_error: got %b required 1", er);
      end
      checks++;
      if (rd !== 32'h0) begin
         errors++; $display("FAIL reject_rdata: got %h required 00000000", rd);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (wr_n !== w0 || rd_n !== r0) begin
         errors++; $display("FAIL reject_no_bus: writes=%0d reads=%0d required 0 0", wr_n - w0, rd_n - r0);
      end
   endtask

   task automatic test_single();
      int who, at, c0, w0; logic [31:0] rd; logic er;
      @(negedge clk);
      w0 = wr_n;
      m_resp = 32'h1234_5678;
      sif.req_slave[7:0]  = 8'd0;
      sif.req_wdata[31:0] = 32'hA5A5_0F0F;
      c0 = cyc;
      sif.req[0] = 1'b1;
      wait_any(1'b1, 400, who, at, rd, er);
      checks++;
      if (who !== 0 || at !== c0 + 167) begin
         errors++; $display("FAIL single_latency: who=%0d at=+%0d required who=0 at=+167", who, at - c0);
      end
      checks++;
      if (rd !== 32'h1234_5678) begin
         errors++; $display("FAIL single_rdata: got %h required 12345678", rd);
      end
      checks++;
      if (er !== 1'b0) begin
         errors++; $display("FAIL single_error: got %b required 0", er);
      end
      checks++;
      if (wr_n - w0 !== 3) begin
         errors++; $display("FAIL single_wr_count: got %0d required 3", wr_n - w0);
      end
      checks++;
      if (wr_addr[w0] !== 2'd2 || wr_data[w0] !== 32'hA5A5_0F0F) begin
         errors++; $display("FAIL single_wr0: got (%0d,%h) required (2,a5a50f0f)", wr_addr[w0], wr_data[w0]);
      end
      checks++;
      if (wr_addr[w0+1] !== 2'd1 || wr_data[w0+1] !== 32'h0) begin
         errors++; $display("FAIL single_wr1: got (%0d,%h) required (1,00000000)", wr_addr[w0+1], wr_data[w0+1]);
      end
      checks++;
      if (wr_addr[w0+2] !== 2'd0 || wr_data[w0+2] !== 32'h0) begin
         errors++; $display("FAIL single_wr2: got (%0d,%h) required (0,00000000)", wr_addr[w0+2], wr_data[w0+2]);
      end
      checks++;
      if (m_mosi !== 32'hA5A5_0F0F) begin
         errors++; $display("FAIL single_mosi: got %h required a5a50f0f", m_mosi);
      end
      @(negedge clk);
      checks++;
      if (sif.resp_valid !== 2'b00 || sif.busy !== 1'b0) begin
         errors++; $display("FAIL single_after: valid=%b busy=%b required 00 0", sif.resp_valid, sif.busy);
      end
   endtask

   task automatic test_fairness();
      int who1, who2, who3, at; logic [31:0] rd; logic er;
      @(negedge clk);
      sif.req_slave = 16'h0000;
      sif.req[1] = 1'b1;
      repeat (20) @(negedge clk);
      sif.req[0] = 1'b1;
      wait_any(1'b0, 400, who1, at, rd, er);
      wait_any(1'b1, 400, who2, at, rd, er);
      wait_any(1'b1, 400, who3, at, rd, er);
      checks++;
      if (who1 !== 1) begin
         errors++; $display("FAIL fair_first: got %0d required 1", who1);
      end
      checks++;
      if (who2 !== 0) begin
         errors++; $display("FAIL fair_second: got %0d required 0", who2);
      end
      checks++;
      if (who3 !== 1) begin
         errors++; $display("FAIL fair_third: got %0d required 1", who3);
      end
   endtask

   task automatic test_reset_mid_wait();
      int who, at, c0, p0; logic [31:0] rd; logic er;
      @(negedge clk);
      sif.req_slave[7:0]  = 8'd0;
      sif.req_wdata[31:0] = 32'h7777_0000;
      sif.req[0] = 1'b1;
      repeat (20) @(negedge clk);
      checks++;
      if (sif.busy !== 1'b1) begin
         errors++; $display("FAIL rstwait_busy_before: got %b required 1", sif.busy);
      end
      p0 = pulse_cnt[0];
      reset_n = 1'b0;
      sif.req[0] = 1'b0;
      #1;
      checks++;
      if (sif.busy !== 1'b0 || sif.resp_valid !== 2'b00 || sif.resp_error !== 1'b0 || sif.resp_rdata !== 32'h0) begin
         errors++; $display("FAIL rstwait_resp: busy=%b valid=%b err=%b rdata=%h required all 0",
                            sif.busy, sif.resp_valid, sif.resp_error, sif.resp_rdata);
      end
      checks++;
      if (sif.avm_read !== 1'b0 || sif.avm_write !== 1'b0 || sif.avm_address !== 2'd0 || sif.avm_writedata !== 32'h0) begin
         errors++; $display("FAIL rstwait_avm: rd=%b wr=%b addr=%0d wd=%h required all 0",
                            sif.avm_read, sif.avm_write, sif.avm_address, sif.avm_writedata);
      end
      @(negedge clk);
      reset_n = 1'b1;
      repeat (200) @(negedge clk);
      checks++;
      if (pulse_cnt[0] !== p0) begin
         errors++; $display("FAIL rstwait_no_resp: got %0d pulses required 0", pulse_cnt[0] - p0);
      end
      m_resp = 32'h5555_AAAA;
      sif.req_wdata[31:0] = 32'h0F0F_1234;
      c0 = cyc;
      sif.req[0] = 1'b1;
      wait_any(1'b1, 400, who, at, rd, er);
      checks++;
      if (who !== 0 || at !== c0 + 167 || rd !== 32'h5555_AAAA) begin
         errors++; $display("FAIL rstwait_after: who=%0d at=+%0d rdata=%h required who=0 at=+167 rdata=5555aaaa",
                            who, at - c0, rd);
      end
      checks++;
      if (m_mosi !== 32'h0F0F_1234) begin
         errors++; $display("FAIL rstwait_mosi: got %h required 0f0f1234", m_mosi);
      end
   endtask

   task automatic test_wdata_latch();
      int who, at; logic [31:0] rd; logic er;
      @(negedge clk);
      m_resp = 32'hCAFE_0001;
      sif.req_slave[7:0]  = 8'd0;
      sif.req_wdata[31:0] = 32'hDEAD_BEEF;
      sif.req[0] = 1'b1;
      repeat (30) @(negedge clk);
      sif.req_wdata[31:0] = 32'h0BAD_F00D;
      sif.req_slave[7:0]  = 8'd3;
      wait_any(1'b1, 400, who, at, rd, er);
      checks++;
      if (m_mosi !== 32'hDEAD_BEEF) begin
         errors++; $display("FAIL latch_mosi: got %h required deadbeef", m_mosi);
      end
      checks++;
      if (who !== 0 || rd !== 32'hCAFE_0001 || er !== 1'b0) begin
         errors++; $display("FAIL latch_resp: who=%0d rdata=%h err=%b required 0 cafe0001 0", who, rd, er);
      end
   endtask

   task automatic test_bus_rules();
      checks++;
      if (bus_viol !== 0) begin
         errors++; $display("FAIL bus_rd_wr_overlap: got %0d cycles required 0", bus_viol);
      end
   endtask

   initial begin
      test_reset();
      test_simultaneous(0, 1, "pair_a");
      test_reject();
      test_single();
      test_simultaneous(1, 0, "pair_b");
      test_fairness();
      test_reset_mid_wait();
      test_wdata_latch();
      test_bus_rules();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/spi_master_scheduler.md
Name: spi_master_scheduler

Overview:
Shares one spi_master instance between NUM_REQ independent requesters. Each requester asks for one 32-bit full-duplex transfer to a chosen slave. The scheduler arbitrates round-robin and sequences the transfer over spi_master's Avalon slave port: load data, clear RX, select slave and start, wait, read RX. It then returns the received word to the granted requester. It sits between the CPU-side and peripheral-side clients and the spi_master Avalon slave.

Parameters:
NUM_REQ, 2, number of requesters (1..8)
NUMBER_SLAVES, 1, slave count of the attached spi_master; slave indices >= this are rejected
XFER_WAIT_CYCLES, 160, clk cycles from the start-write to a safe RX read; must be >= 140 for a 32-bit frame at SPI_CLK_DIV=2
SLV_W, 8, width of each requester's slave-index field

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
req  in  NUM_REQ  per-requester transfer request, level, held until resp_valid
req_slave  in  NUM_REQ*SLV_W  slave index for each requester, concatenated with requester i at [i*SLV_W +: SLV_W]
req_wdata  in  NUM_REQ*32  TX word for each requester, concatenated with requester i at [i*32 +: 32]
resp_valid  out  NUM_REQ  one-cycle completion pulse to the granted requester
resp_rdata  out  32  RX word, valid with resp_valid
resp_error  out  1  valid with resp_valid; 1 = slave index out of range, no SPI activity
busy  out  1  high in every state except IDLE
avm_address  out  2  to spi_master avs_address
avm_read  out  1  to spi_master avs_read
avm_write  out  1  to spi_master avs_write
avm_writedata  out  32  to spi_master avs_writedata
avm_readdata  in  32  from spi_master avs_readdata; registered, valid the cycle after avm_read

Behaviour:
- Clock and reset: one clock domain, clk. Reset is asynchronous and active-low on reset_n.
- Reset values: every output is 0. The round-robin pointer is 0 and the state is IDLE.
- spi_master register map: address 0 = slave select (a write starts the transfer), address 1 = data in, address 2 = data out.
- Avalon master rules:
  - Every access lasts exactly one cycle, with no waitrequest.
  - avm_read and avm_write are never high together.
- States:
  - IDLE: if any req bit is high, grant the highest-priority one. Priority starts at pointer and wraps upward. Latch gnt, slave and wdata into registers, then go to CHECK.
  - CHECK: if slave >= NUMBER_SLAVES, go to DONE with err=1. Otherwise go to WR_DOUT.
  - WR_DOUT: avm_write=1, address=2, writedata=wdata. Go to WR_CLR.
  - WR_CLR: avm_write=1, address=1, writedata=0. Go to WR_SS.
  - WR_SS: avm_write=1, address=0, writedata=slave zero-extended. Load the wait counter with XFER_WAIT_CYCLES-1 and go to WAIT.
  - WAIT: decrement the counter; when it reaches 0, go to RD.
  - RD: avm_read=1, address=1. Go to CAP.
  - CAP: register avm_readdata into the RX register. Go to DONE.
  - DONE: resp_valid[gnt]=1 for one cycle. resp_rdata = RX register (0 on error); resp_error = err. Set pointer = (gnt+1) mod NUM_REQ and go to IDLE.
- Latency:
  - Valid request: req sampled in IDLE at cycle t gives resp_valid at t+7+XFER_WAIT_CYCLES.
  - Rejected request: resp_valid at t+2.
- Handshake rules:
  - Requester inputs are sampled only in IDLE; later changes are ignored.
  - A requester must drop req in the cycle after resp_valid; otherwise it is treated as a new request.
  - req dropping before resp_valid does not abort the transfer; the response is still delivered.
- Simultaneous requests: the pointer gives fairness. Every pending requester is served within NUM_REQ grants.
- Wait counter: sized $clog2(XFER_WAIT_CYCLES+1). It never wraps, because it is loaded only in WR_SS.
- Reset mid-operation: all state is cleared immediately and no resp_valid is issued. spi_master shares reset_n, so no bus cleanup is needed.
- Illegal state encodings recover to IDLE.

Decomposition:
- Shared package spi_master_pkg holds:
  - spi_master register address constants (SLAVE_SELECT_ADDR=0, SPI_DATA_IN_ADDR=1, SPI_DATA_OUT_ADDR=2);
  - the scheduler state enum;
  - the 32-bit word width constant.
- One sub-module, spi_rr_arbiter. It is combinational: req vector plus pointer in, one-hot grant and grant index out.

Test Plan:
- NUM_REQ=2. req[0] with slave=0, wdata=32'hA5A5_0F0F; bench slave returns 32'h1234_5678. Expected:
  - Avalon writes in order: (2, A5A50F0F), (1, 0), (0, 0);
  - MOSI frame equals A5A50F0F;
  - resp_valid[0] after 7+160 cycles with rdata=12345678 and error=0.
- req[0] and req[1] raised in the same cycle -> requester 0 is served first, then requester 1; each gets exactly one resp_valid pulse. A second simultaneous pair is served 1 then 0.
- req[1] with slave=5 and NUMBER_SLAVES=1 -> no avm_write at all; resp_valid[1] 2 cycles after the grant with error=1 and rdata=0.
- req[1] held high continuously and req[0] raised mid-transfer -> the next grant goes to 0. There are no back-to-back grants to 1 while 0 is pending.
- reset_n asserted during WAIT -> on the same edge all outputs are 0 and busy=0. After release, a new req[0] completes normally.
- req_wdata changed during WAIT -> the MOSI frame still carries the value latched in IDLE.
